// File: rtl/mshr_refill_ctrl_if.sv
// rtl/mshr_refill_ctrl_if.sv - handshake bundle between MSHR table, memory read port, data array and refill sequencer
//
// Ports carried:
//   alloc_*      MSHR -> sequencer  new entry allocation
//   mem_req_*    sequencer <-> mem  line-read request (valid/ready)
//   mem_resp_*   mem -> sequencer   response beats (no backpressure)
//   fill_*       sequencer -> array registered beat writes
//   mem_refill_* sequencer -> MSHR  line-complete pulse
//   busy, protocol_err              status
// Modports: master = refill sequencer side, slave = surrounding environment.
interface mshr_refill_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int NUM_MSHR   = 4
);
    localparam int ID_W        = $clog2(NUM_MSHR);
    localparam int OFFSET_W    = $clog2(LINE_BYTES);
    localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;
    localparam int BEATS       = LINE_BYTES / (DATA_W / 8);
    localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                   alloc_fire;
    logic [ID_W-1:0]        alloc_id;
    logic [LINE_ADDR_W-1:0] alloc_line_addr;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic [ID_W-1:0]        mem_req_id;
    logic                   mem_resp_valid;
    logic [ID_W-1:0]        mem_resp_id;
    logic [DATA_W-1:0]      mem_resp_data;
    logic                   mem_resp_last;
    logic                   fill_valid;
    logic [ID_W-1:0]        fill_id;
    logic [BEAT_W-1:0]      fill_beat;
    logic [DATA_W-1:0]      fill_data;
    logic                   mem_refill_valid;
    logic [ID_W-1:0]        mem_refill_id;
    logic                   busy;
    logic                   protocol_err;

    modport master (
        input  alloc_fire, alloc_id, alloc_line_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_id, mem_resp_data, mem_resp_last,
        output mem_req_valid, mem_req_addr, mem_req_id,
        output fill_valid, fill_id, fill_beat, fill_data,
        output mem_refill_valid, mem_refill_id,
        output busy, protocol_err
    );

    modport slave (
        output alloc_fire, alloc_id, alloc_line_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_id, mem_resp_data, mem_resp_last,
        input  mem_req_valid, mem_req_addr, mem_req_id,
        input  fill_valid, fill_id, fill_beat, fill_data,
        input  mem_refill_valid, mem_refill_id,
        input  busy, protocol_err
    );
endinterface

// File: rtl/mshr_refill_ctrl.sv
// rtl/mshr_refill_ctrl.sv - MSHR refill sequencer: in-order request issue, beat steering, refill completion
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mshr_refill_ctrl_if.master: alloc in, mem request out, mem response in,
//          fill beats out, refill pulse out, busy / sticky protocol_err out
module mshr_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int NUM_MSHR   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mshr_refill_ctrl_if.master  bus
);
    localparam int ID_W        = $clog2(NUM_MSHR);
    localparam int OFFSET_W    = $clog2(LINE_BYTES);
    localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;
    localparam int BEATS       = LINE_BYTES / (DATA_W / 8);
    localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUEUED,
        ST_ISSUED,
        ST_FILLING
    } id_state_e;

    id_state_e              st        [NUM_MSHR];
    logic [LINE_ADDR_W-1:0] line_addr [NUM_MSHR];
    logic [BEAT_W-1:0]      beat_cnt  [NUM_MSHR];

    // Issue FIFO of ids; depth NUM_MSHR suffices since only IDLE ids get pushed.
    logic [ID_W-1:0]        q_mem     [NUM_MSHR];
    logic [ID_W-1:0]        q_rd;
    logic [ID_W-1:0]        q_wr;
    logic [ID_W:0]          q_cnt;

    logic                   q_empty;
    logic [ID_W-1:0]        head_id;
    logic                   pop;
    logic                   push;
    logic                   resp_hit;
    logic [BEAT_W-1:0]      resp_cnt;
    logic                   resp_at_end;
    logic                   busy_c;

    assign q_empty  = (q_cnt == '0);
    assign head_id  = q_mem[q_rd];
    assign pop      = !q_empty && bus.mem_req_ready;
    // Alloc legality is judged on the pre-edge state of the id.
    assign push     = bus.alloc_fire && (st[bus.alloc_id] == ST_IDLE);
    assign resp_hit = bus.mem_resp_valid &&
                      ((st[bus.mem_resp_id] == ST_ISSUED) || (st[bus.mem_resp_id] == ST_FILLING));
    assign resp_cnt    = beat_cnt[bus.mem_resp_id];
    assign resp_at_end = (resp_cnt == BEAT_W'(BEATS - 1));

    // Request fields are a pure function of the queue head, so they stay stable
    // until the handshake pops it. Forced to zero while empty.
    assign bus.mem_req_valid = !q_empty;
    assign bus.mem_req_id    = q_empty ? '0 : head_id;
    assign bus.mem_req_addr  = q_empty ? '0 : {line_addr[head_id], {OFFSET_W{1'b0}}};

    always_comb begin
        busy_c = 1'b0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (st[i] != ST_IDLE) busy_c = 1'b1;
        end
    end
    assign bus.busy = busy_c;

    // The response, pop and alloc paths can only touch the same id if their
    // pre-edge states differ (ISSUED/FILLING vs QUEUED vs IDLE), so at most one
    // of them actually writes any given id's state in a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                st[i]        <= ST_IDLE;
                line_addr[i] <= '0;
                beat_cnt[i]  <= '0;
                q_mem[i]     <= '0;
            end
            q_rd                 <= '0;
            q_wr                 <= '0;
            q_cnt                <= '0;
            bus.fill_valid       <= 1'b0;
            bus.fill_id          <= '0;
            bus.fill_beat        <= '0;
            bus.fill_data        <= '0;
            bus.mem_refill_valid <= 1'b0;
            bus.mem_refill_id    <= '0;
            bus.protocol_err     <= 1'b0;
        end else begin
            bus.fill_valid       <= resp_hit;
            bus.mem_refill_valid <= resp_hit && bus.mem_resp_last;

            if (resp_hit) begin
                bus.fill_id   <= bus.mem_resp_id;
                bus.fill_beat <= resp_cnt;
                bus.fill_data <= bus.mem_resp_data;
                if (bus.mem_resp_last) begin
                    bus.mem_refill_id          <= bus.mem_resp_id;
                    st[bus.mem_resp_id]        <= ST_IDLE;
                    beat_cnt[bus.mem_resp_id]  <= '0;
                    if (!resp_at_end) bus.protocol_err <= 1'b1;
                end else begin
                    // A missing last on the final beat wraps the counter and keeps filling.
                    st[bus.mem_resp_id]       <= ST_FILLING;
                    beat_cnt[bus.mem_resp_id] <= resp_at_end ? '0 : resp_cnt + 1'b1;
                    if (resp_at_end) bus.protocol_err <= 1'b1;
                end
            end else if (bus.mem_resp_valid) begin
                // Beat for an id that has no outstanding request: dropped.
                bus.protocol_err <= 1'b1;
            end

            if (pop) begin
                st[head_id] <= ST_ISSUED;
                q_rd        <= q_rd + 1'b1;
            end

            if (bus.alloc_fire) begin
                if (push) begin
                    st[bus.alloc_id]        <= ST_QUEUED;
                    line_addr[bus.alloc_id] <= bus.alloc_line_addr;
                    beat_cnt[bus.alloc_id]  <= '0;
                    q_mem[q_wr]             <= bus.alloc_id;
                    q_wr                    <= q_wr + 1'b1;
                end else begin
                    bus.protocol_err <= 1'b1;
                end
            end

            q_cnt <= q_cnt + {{ID_W{1'b0}}, push} - {{ID_W{1'b0}}, pop};
        end
    end
endmodule
